cmd_sequencer: RTL and testbench

- Synthesizable command engine. It executes a stream of encoded commands that drive the shared output pair a/b: AAA sets a to a sum, BBB sets b, WAIT stalls for N cycles, and DONE halts the engine.
- A small command FIFO sits between the producer and the executor. The producer (CPU bridge, ROM loader or bench) pushes commands with a valid/ready handshake.
- The executor pops and applies the commands strictly in order, one per cycle unless stalled.

---
 rtl/cmd_sequencer_if.sv | 14 +
 rtl/cmd_sequencer.sv | 153 +++++++++++++++
 tb/tb_cmd_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/cmd_sequencer_if.sv
// Command push channel between a producer and the cmd_sequencer.
// The producer drives valid/op/args; the sequencer drives ready.
interface cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_arg0;
  logic [7:0] cmd_arg1;

  modport master (output cmd_valid, output cmd_op, output cmd_arg0, output cmd_arg1,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_op, input  cmd_arg0, input  cmd_arg1,
                  output cmd_ready);
endinterface

// File: rtl/cmd_sequencer.sv
// cmd_sequencer: small command FIFO feeding an in-order executor that drives
// the a/b outputs. AAA loads a with a nibble sum, BBB loads b, WAIT stalls for
// N cycles and DONE halts the engine until the next reset.
module cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  cmd_sequencer_if.slave   cmd,
  output logic [4:0]       a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] fifo_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [1:0] OP_AAA  = 2'd0;
  localparam logic [1:0] OP_BBB  = 2'd1;
  localparam logic [1:0] OP_WAIT = 2'd2;
  localparam logic [1:0] OP_DONE = 2'd3;

  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, HALT = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [7:0]       wait_cnt, wait_nxt;
  logic [4:0]       a_nxt;
  logic             b_nxt, done_nxt, flush;
  logic [17:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push, pop;
  logic [17:0]      head;
  logic [1:0]       head_op;
  logic [7:0]       head_arg0, head_arg1;
  logic             unused_arg_bits;

  // ready comes only from registered state, never from the pop decision
  assign cmd.cmd_ready = (fifo_cnt != CNT_W'(FIFO_DEPTH)) && !done;
  assign push          = cmd.cmd_valid && cmd.cmd_ready;
  assign pop           = (state == RUN) && (fifo_cnt != {CNT_W{1'b0}});
  assign busy          = (fifo_cnt != {CNT_W{1'b0}}) || (state == STALL);

  assign head      = mem[rd_ptr];
  assign head_op   = head[17:16];
  assign head_arg0 = head[15:8];
  assign head_arg1 = head[7:0];
  // upper nibble of arg1 has no use in any command
  assign unused_arg_bits = ^head_arg1[7:4];

  // FIFO storage: write the incoming command at the write pointer
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd.cmd_op, cmd.cmd_arg0, cmd.cmd_arg1};
    end
  end

  // Executor next-state and datapath decode
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    a_nxt     = a;
    b_nxt     = b;
    done_nxt  = done;
    flush     = 1'b0;
    case (state)
      RUN: begin
        if (pop) begin
          case (head_op)
            OP_AAA:  a_nxt = {1'b0, head_arg0[3:0]} + {1'b0, head_arg1[3:0]};
            OP_BBB:  b_nxt = head_arg0[0];
            OP_WAIT: begin
              if (head_arg0 != 8'd0) begin
                wait_nxt  = head_arg0 - 8'd1;
                state_nxt = STALL;
              end else begin
                state_nxt = RUN;
              end
            end
            OP_DONE: begin
              done_nxt  = 1'b1;
              flush     = 1'b1;
              state_nxt = HALT;
            end
            default: state_nxt = RUN;
          endcase
        end else begin
          state_nxt = RUN;
        end
      end
      STALL: begin
        if (wait_cnt == 8'd0) begin
          state_nxt = RUN;
        end else begin
          wait_nxt = wait_cnt - 8'd1;
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = RUN;
    endcase
  end

  // Executor state, wait counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
      a        <= 5'd0;
      b        <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      a        <= a_nxt;
      b        <= b_nxt;
      done     <= done_nxt;
    end
  end

  // FIFO pointers and occupancy; DONE empties the queue in the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= {PTR_W{1'b0}};
      rd_ptr   <= {PTR_W{1'b0}};
      fifo_cnt <= {CNT_W{1'b0}};
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr <= wr_ptr;
      end
      if (flush) begin
        rd_ptr   <= push ? (wr_ptr + {{(PTR_W-1){1'b0}}, 1'b1}) : wr_ptr;
        fifo_cnt <= {CNT_W{1'b0}};
      end else begin
        if (pop) begin
          rd_ptr <= rd_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
          rd_ptr <= rd_ptr;
        end
        if (push && !pop) begin
          fifo_cnt <= fifo_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (pop && !push) begin
          fifo_cnt <= fifo_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          fifo_cnt <= fifo_cnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed testbench for cmd_sequencer: hand-computed expectations for
// arithmetic, WAIT timing, back-pressure, DONE flush and async reset.
module tb_cmd_sequencer;

  logic       clk;
  logic       rst_n;
  logic [4:0] a;
  logic       b;
  logic       busy;
  logic       done;
  logic [2:0] fifo_cnt;
  int         total;
  int         bad;
  int         cyc;
  int         t_wait;
  int         t_acc;
  int         ready_hi;
  int         b_hi;

  cmd_sequencer_if bus();

  cmd_sequencer #(.FIFO_DEPTH(4), .CNT_W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd      (bus),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .fifo_cnt (fifo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // free-running edge counter used to time command acceptance
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // step n rising edges, landing 1 time unit after the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // offer one command, hold it until accepted; returns the accept edge count
  task automatic push(input logic [1:0] op, input logic [7:0] a0, input logic [7:0] a1,
                      output int acc);
    int guard;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_arg0  = a0;
    bus.cmd_arg1  = a1;
    guard = 0;
    while (!bus.cmd_ready && guard < 400) begin
      @(negedge clk);
      guard = guard + 1;
    end
    if (guard >= 400) chk("push_timeout", guard, 0);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    acc = cyc;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_arg0  = 8'd0;
    bus.cmd_arg1  = 8'd0;
    rst_n = 1'b0;
    #12;
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", fifo_cnt, 0);
    chk("rst_ready", bus.cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // basic AAA: one entry queued, popped on the next edge
    push(2'd0, 8'd3, 8'd5, t_acc);
    chk("aaa_cnt_after_push", fifo_cnt, 1);
    chk("aaa_busy_after_push", busy, 1);
    tick(1);
    chk("aaa_3_5", a, 8);
    chk("aaa_b", b, 0);
    chk("aaa_idle_busy", busy, 0);
    chk("aaa_idle_cnt", fifo_cnt, 0);

    // nibble arithmetic; upper argument nibbles ignored
    push(2'd0, 8'd15, 8'd15, t_acc);
    push(2'd0, 8'd1, 8'd1, t_acc);
    chk("aaa_15_15", a, 30);
    chk("simul_push_pop_cnt", fifo_cnt, 1);
    push(2'd0, 8'h1F, 8'h2F, t_acc);
    chk("aaa_1_1", a, 2);
    tick(1);
    chk("aaa_upper_nibbles", a, 30);

    // BBB(1), WAIT(4), BBB(0): second BBB lands 5 edges after the WAIT pop
    push(2'd1, 8'd1, 8'd0, t_acc);
    push(2'd2, 8'd4, 8'd0, t_acc);
    push(2'd1, 8'd0, 8'd0, t_acc);
    chk("bbb_set", b, 1);
    chk("stall_busy", busy, 1);
    tick(3);
    chk("stall_hold_b", b, 1);
    tick(1);
    chk("stall_hold_b_last", b, 1);
    tick(1);
    chk("after_wait4_b", b, 0);

    // WAIT(0) is a plain no-op pop
    push(2'd2, 8'd0, 8'd0, t_acc);
    push(2'd1, 8'd1, 8'd0, t_acc);
    chk("wait0_b_before", b, 0);
    tick(1);
    chk("wait0_no_stall_b", b, 1);
    chk("wait0_busy", busy, 0);

    // back-pressure while stalled on WAIT(200)
    push(2'd2, 8'd200, 8'd0, t_wait);
    push(2'd0, 8'd1, 8'd0, t_acc);
    push(2'd0, 8'd2, 8'd0, t_acc);
    push(2'd0, 8'd3, 8'd0, t_acc);
    push(2'd0, 8'd4, 8'd0, t_acc);
    chk("full_cnt", fifo_cnt, 4);
    chk("full_ready", bus.cmd_ready, 0);
    tick(100);
    chk("full_hold_cnt", fifo_cnt, 4);
    push(2'd0, 8'd5, 8'd0, t_acc);
    chk("fifth_accept_edge", t_acc - t_wait, 203);
    chk("fifth_accept_a", a, 2);
    chk("fifth_accept_cnt", fifo_cnt, 3);
    tick(3);
    chk("drain_a", a, 5);
    chk("drain_cnt", fifo_cnt, 0);

    // DONE halts, flushes the trailing BBB and blocks the producer
    push(2'd1, 8'd0, 8'd0, t_acc);
    push(2'd0, 8'd1, 8'd2, t_acc);
    push(2'd3, 8'd0, 8'd0, t_acc);
    push(2'd1, 8'd1, 8'd0, t_acc);
    chk("done_a", a, 3);
    chk("done_flag", done, 1);
    chk("done_cnt", fifo_cnt, 0);
    chk("done_busy", busy, 0);
    ready_hi = 0;
    b_hi = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (bus.cmd_ready) ready_hi = ready_hi + 1;
      if (b) b_hi = b_hi + 1;
    end
    chk("halt_ready_cycles", ready_hi, 0);
    chk("halt_b_cycles", b_hi, 0);
    chk("halt_done_hold", done, 1);

    // async reset in the middle of a stall with entries queued
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    push(2'd0, 8'd7, 8'd7, t_acc);
    push(2'd1, 8'd1, 8'd0, t_acc);
    push(2'd2, 8'd50, 8'd0, t_acc);
    push(2'd0, 8'd1, 8'd1, t_acc);
    push(2'd0, 8'd2, 8'd1, t_acc);
    push(2'd1, 8'd0, 8'd0, t_acc);
    chk("pre_rst_a", a, 14);
    chk("pre_rst_b", b, 1);
    chk("pre_rst_cnt", fifo_cnt, 3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_a", a, 0);
    chk("async_rst_b", b, 0);
    chk("async_rst_cnt", fifo_cnt, 0);
    chk("async_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    push(2'd0, 8'd2, 8'd2, t_acc);
    tick(1);
    chk("post_rst_a", a, 4);
    chk("post_rst_cnt", fifo_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
